// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Purpose  : SPI mode-0 target (CPOL=0, CPHA=0, MSB first). The SPI pins are
//            brought into the system clock domain through 2-flop
//            synchronizers. Edges are detected on the synchronized sclk. A
//            one-word holding register feeds the transmit shifter.
// Ports    : clock, reset_n      - system clock, async active-low reset
//            sclk, mosi, cs      - SPI pins from the controller (cs active-low)
//            miso, miso_oe       - SPI data out and its tri-state enable
//            tx_data/valid/ready - transmit holding-register handshake
//            rx_data/valid       - last received word, one-cycle strobe
//            tx_underrun         - sticky "shifter loaded from empty holding"
//            underrun_clear      - clears tx_underrun
// Options  : `define SPI_TARGET_UNDERRUN_EN to build the underrun flag;
//            otherwise tx_underrun is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    input  logic                  underrun_clear
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]            r_sclk_sync;
    logic [1:0]            r_mosi_sync;
    logic [1:0]            r_cs_sync;
    logic [1:0]            r_warm;
    logic                  r_sclk_d;
    logic                  r_cs_d;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_full;
    logic                  r_word_done;

    logic                  w_sclk_s;
    logic                  w_cs_s;
    logic                  w_mosi_s;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic                  w_load;
    logic                  w_hold_wr;
    logic                  w_consume;
    logic [DATA_WIDTH-1:0] w_load_word;

    assign w_sclk_s    = r_sclk_sync[1];
    assign w_cs_s      = r_cs_sync[1];
    assign w_mosi_s    = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = r_cs_d & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_d & w_cs_s;

    assign w_load_word = r_hold_full ? r_hold_data : IDLE_FILL;
    assign w_hold_wr   = tx_valid & ~r_hold_full;
    assign w_consume   = w_load & r_hold_full;
    assign tx_ready    = ~r_hold_full;
    assign miso_oe     = ~w_cs_s;

    // Synchronizers and edge-detect history. r_warm marks when the cs chain
    // holds real pin samples rather than reset values; r_cs_d only reports
    // "high" for a genuinely sampled high, so a cs held low across reset
    // release is not mistaken for a fresh falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_warm      <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_warm      <= {r_warm[0], 1'b1};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s & r_warm[1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, shifter-load request and miso.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        miso         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_SHIFT;
                    w_load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                miso = r_tx_shift[DATA_WIDTH-1];
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                end else if (w_sclk_fall && (r_bit_cnt == c_CNT_FULL)) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Holding register. A write can only happen while empty, so a write and
    // a consume never collide; the write still takes priority for safety.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_hold_wr) begin
            r_hold_full <= 1'b1;
            r_hold_data <= tx_data;
        end else if (w_consume) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shifters and bit counter. The counter parks at DATA_WIDTH after the
    // last rise and is cleared by the following fall, which also reloads
    // the transmit shifter for the next word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
                if (w_load) begin
                    r_tx_shift <= w_load_word;
                end
            end else if (w_cs_rise) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise && (r_bit_cnt != c_CNT_FULL)) begin
                r_rx_shift  <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
                r_bit_cnt   <= r_bit_cnt + c_CNT_ONE;
                r_word_done <= (r_bit_cnt == c_CNT_LAST);
            end else if (w_sclk_fall) begin
                if (w_load) begin
                    r_tx_shift <= w_load_word;
                    r_bit_cnt  <= '0;
                end else begin
                    r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Receive output register, one cycle after the counter reaches full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= r_word_done;
            if (r_word_done) begin
                rx_data <= r_rx_shift;
            end
        end
    end

`ifdef SPI_TARGET_UNDERRUN_EN
    logic r_underrun;

    // Set has priority over clear so an underrun is never lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_load && !r_hold_full) begin
            r_underrun <= 1'b1;
        end else if (underrun_clear) begin
            r_underrun <= 1'b0;
        end
    end

    assign tx_underrun = r_underrun;
`else
    logic w_unused_underrun_clear;

    assign w_unused_underrun_clear = underrun_clear;
    assign tx_underrun             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Purpose  : Self-checking bench for spi_target (DATA_WIDTH = 8). Drives a
//            mode-0 controller at sclk = clock/8 and checks miso words,
//            received words (scoreboard queue), handshake and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    localparam int DW = 8;
`ifdef SPI_TARGET_UNDERRUN_EN
    localparam logic c_UR_EXP = 1'b1;
`else
    localparam logic c_UR_EXP = 1'b0;
`endif

    logic          clock          = 1'b0;
    logic          reset_n        = 1'b0;
    logic          sclk           = 1'b0;
    logic          mosi           = 1'b0;
    logic          cs             = 1'b1;
    logic          tx_valid       = 1'b0;
    logic          underrun_clear = 1'b0;
    logic [DW-1:0] tx_data        = '0;
    logic          miso;
    logic          miso_oe;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_underrun;

    int            checks     = 0;
    int            errors     = 0;
    int            cyc        = 0;
    int            last_rise  = 0;
    int            pulses     = 0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] mo;
        logic [DW-1:0] exp_miso;
        logic [DW-1:0] exp_rx;
    } vec_t;

    spi_target #(
        .DATA_WIDTH (DW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sclk           (sclk),
        .mosi           (mosi),
        .cs             (cs),
        .miso           (miso),
        .miso_oe        (miso_oe),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_underrun    (tx_underrun),
        .underrun_clear (underrun_clear)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every rx_valid pops one expected word.
    always @(negedge clock) begin
        if (rx_valid === 1'b1) begin
            int lat;
            pulses++;
            check("rx_valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h expected no word", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            lat = cyc - last_rise;
            checks++;
            if (lat < 3 || lat > 4) begin
                errors++;
                $display("FAIL rx_latency: got %0d expected 3..4", lat);
            end
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_tx(input logic [DW-1:0] d);
        int i;
        i = 0;
        while (tx_ready !== 1'b1 && i < 200) begin
            tick(1);
            i++;
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_wait: got %b expected 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic clear_underrun();
        underrun_clear = 1'b1;
        tick(1);
        underrun_clear = 1'b0;
        tick(1);
    endtask

    task automatic cs_start();
        cs = 1'b0;
        tick(8);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        tick(8);
    endtask

    // Shift n bits (MSB first); miso is sampled just before each rise.
    task automatic spi_bits(input logic [DW-1:0] mo, input int n, output logic [DW-1:0] mi);
        mi = '0;
        for (int b = DW - 1; b >= DW - n; b--) begin
            mosi = mo[b];
            tick(4);
            mi[b]     = miso;
            sclk      = 1'b1;
            last_rise = cyc;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
    endtask

    initial begin
        vec_t          vecs[5];
        logic [DW-1:0] got;
        int            p0;

        vecs[0] = '{tx: 8'hA5, mo: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'h00, mo: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
        vecs[2] = '{tx: 8'hFF, mo: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00};
        vecs[3] = '{tx: 8'h5A, mo: 8'h81, exp_miso: 8'h5A, exp_rx: 8'h81};
        vecs[4] = '{tx: 8'hC3, mo: 8'h7E, exp_miso: 8'hC3, exp_rx: 8'h7E};

        // Reset values
        tick(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Single-word transfers from the table
        for (int v = 0; v < 5; v++) begin
            p0 = pulses;
            write_tx(vecs[v].tx);
            check("tx_ready_low", {31'd0, tx_ready}, 32'd0);
            exp_q.push_back(vecs[v].exp_rx);
            cs_start();
            check("miso_oe_active", {31'd0, miso_oe}, 32'd1);
            check("tx_ready_consumed", {31'd0, tx_ready}, 32'd1);
            spi_bits(vecs[v].mo, 8, got);
            cs_end();
            check("miso_word", {24'd0, got}, {24'd0, vecs[v].exp_miso});
            check("rx_pulses", pulses - p0, 32'd1);
            check("miso_idle", {31'd0, miso}, 32'd0);
            check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
        end

        // Back-to-back words with the second word loaded during the first
        clear_underrun();
        p0 = pulses;
        write_tx(8'h12);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        cs_start();
        write_tx(8'h34);
        spi_bits(8'h5A, 8, got);
        check("b2b_miso0", {24'd0, got}, 32'h12);
        check("b2b_underrun", {31'd0, tx_underrun}, 32'd0);
        spi_bits(8'hC3, 8, got);
        check("b2b_miso1", {24'd0, got}, 32'h34);
        cs_end();
        check("b2b_pulses", pulses - p0, 32'd2);

        // Transfer with nothing written
        clear_underrun();
        check("ur_cleared0", {31'd0, tx_underrun}, 32'd0);
        cs_start();
        check("ur_set", {31'd0, tx_underrun}, {31'd0, c_UR_EXP});
        exp_q.push_back(8'h99);
        spi_bits(8'h99, 8, got);
        cs_end();
        check("ur_miso_fill", {24'd0, got}, 32'h00);
        check("ur_tx_ready", {31'd0, tx_ready}, 32'd1);
        clear_underrun();
        check("ur_cleared1", {31'd0, tx_underrun}, 32'd0);

        // cs abort after 5 bits; holding register survives the abort
        p0 = pulses;
        cs_start();
        write_tx(8'h6B);
        spi_bits(8'hA7, 5, got);
        cs_end();
        check("abort_no_pulse", pulses - p0, 32'd0);
        check("abort_hold_kept", {31'd0, tx_ready}, 32'd0);
        exp_q.push_back(8'hFF);
        cs_start();
        spi_bits(8'hFF, 8, got);
        cs_end();
        check("abort_next_miso", {24'd0, got}, 32'h6B);
        check("abort_next_pulses", pulses - p0, 32'd1);
        check("abort_rx_data", {24'd0, rx_data}, 32'hFF);

        // Reset in the middle of a word
        write_tx(8'h77);
        cs_start();
        p0 = pulses;
        spi_bits(8'h0F, 4, got);
        reset_n = 1'b0;
        tick(2);
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_underrun", {31'd0, tx_underrun}, 32'd0);
        reset_n = 1'b1;
        tick(4);
        // cs still low: must not start until a fresh fall
        spi_bits(8'h55, 8, got);
        check("post_rst_no_start_miso", {24'd0, got}, 32'h00);
        check("post_rst_no_pulse", pulses - p0, 32'd0);
        cs_end();
        write_tx(8'h81);
        exp_q.push_back(8'hE7);
        cs_start();
        spi_bits(8'hE7, 8, got);
        cs_end();
        check("post_rst_miso", {24'd0, got}, 32'h81);
        check("post_rst_pulses", pulses - p0, 32'd1);

        tick(4);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
